// File: rtl/fsic_clkdiv_ctrl_if.sv
// Request/acknowledge bundle for the FSIC clock-divider controller.
// The master side requests ratio changes and the slave side runs the divider.
interface fsic_clkdiv_ctrl_if;
  logic       req;
  logic [1:0] div_sel;
  logic       clk_out;
  logic       ack;
  logic       busy;
  logic [1:0] cur_sel;

  modport master (
    output req,
    output div_sel,
    input  clk_out,
    input  ack,
    input  busy,
    input  cur_sel
  );

  modport slave (
    input  req,
    input  div_sel,
    output clk_out,
    output ack,
    output busy,
    output cur_sel
  );
endinterface

// File: rtl/fsic_clkdiv_ctrl.sv
// Power-of-two clock divider with glitch-free ratio changes over a 4-phase req/ack handshake.
// A new ratio always takes effect on a rising edge of clk_out, optionally followed by a high hold.
module fsic_clkdiv_ctrl #(
  parameter logic [1:0] DEFAULT_SEL = 2'd1,
  parameter int         HOLD_CYC    = 2
) (
  input  logic               clk_in,
  input  logic               resetb,
  fsic_clkdiv_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  localparam bit         HOLD_EN   = (HOLD_CYC != 0);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

  logic [1:0] r_state;
  logic [2:0] r_cnt;
  logic       r_clk;
  logic [1:0] r_cur_sel;
  logic [1:0] r_pend_sel;
  logic [3:0] r_hold_cnt;
  logic       r_ack;

  logic [2:0] w_cnt_max;
  logic       w_term;
  logic       w_switch;
  logic       w_accept;

  always_comb begin
    w_cnt_max = 3'd7;
    case (r_cur_sel)
      2'd0:    w_cnt_max = 3'd0;
      2'd1:    w_cnt_max = 3'd1;
      2'd2:    w_cnt_max = 3'd3;
      default: w_cnt_max = 3'd7;
    endcase
  end

  // The switch only happens on the terminal count of a low phase, so the new ratio starts with a fresh high phase.
  assign w_term   = (r_cnt == w_cnt_max);
  assign w_switch = (r_state == S_SYNC) && w_term && !r_clk;
  assign w_accept = (r_state == S_IDLE) && bus.req && !r_ack;

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      r_cnt <= 3'd0;
      r_clk <= 1'b1;
    end else if (r_state == S_HOLD || w_switch) begin
      r_cnt <= 3'd0;
      r_clk <= 1'b1;
    end else if (w_term) begin
      r_cnt <= 3'd0;
      r_clk <= ~r_clk;
    end else begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk_in or negedge resetb) begin
    if (!resetb) begin
      r_state    <= S_IDLE;
      r_cur_sel  <= DEFAULT_SEL;
      r_pend_sel <= 2'd0;
      r_hold_cnt <= 4'd0;
      r_ack      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pend_sel <= bus.div_sel;
            if (bus.div_sel == r_cur_sel) begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
            end else begin
              r_state <= S_SYNC;
            end
          end
        end
        S_SYNC: begin
          if (w_switch) begin
            r_cur_sel <= r_pend_sel;
            if (HOLD_EN) begin
              r_state <= S_HOLD;
            end else begin
              r_state <= S_ACK;
              r_ack   <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_hold_cnt <= 4'd0;
            r_state    <= S_ACK;
            r_ack      <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
          end
        end
        default: begin
          // Leaving ACK needs req low, which is what forces a fresh rising req for the next change.
          if (!bus.req) begin
            r_ack   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.clk_out = r_clk;
  assign bus.ack     = r_ack;
  assign bus.busy    = (r_state != S_IDLE);
  assign bus.cur_sel = r_cur_sel;

endmodule

// File: tb/tb_fsic_clkdiv_ctrl.sv
// Directed bench for fsic_clkdiv_ctrl: one instance with a 2-cycle hold, one with no hold.
// Phase lengths are measured on clk_out and compared against hand-computed counts.
module tb_fsic_clkdiv_ctrl;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic resetbA;
  logic resetbB;

  fsic_clkdiv_ctrl_if ifA ();
  fsic_clkdiv_ctrl_if ifB ();

  fsic_clkdiv_ctrl #(.DEFAULT_SEL(2'd1), .HOLD_CYC(2)) dutA (
    .clk_in (clk_in),
    .resetb (resetbA),
    .bus    (ifA)
  );

  fsic_clkdiv_ctrl #(.DEFAULT_SEL(2'd1), .HOLD_CYC(0)) dutB (
    .clk_in (clk_in),
    .resetb (resetbB),
    .bus    (ifB)
  );

  int checkCount = 0;
  int passCount  = 0;

  logic       useB;
  logic       obsClk;
  logic       obsAck;
  logic       obsBusy;
  logic [1:0] obsSel;

  assign obsClk  = useB ? ifB.clk_out : ifA.clk_out;
  assign obsAck  = useB ? ifB.ack     : ifA.ack;
  assign obsBusy = useB ? ifB.busy    : ifA.busy;
  assign obsSel  = useB ? ifB.cur_sel : ifA.cur_sel;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic stepCycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic req, input logic [1:0] sel);
    if (useB) begin
      ifB.req     = req;
      ifB.div_sel = sel;
    end else begin
      ifA.req     = req;
      ifA.div_sel = sel;
    end
  endtask

  task automatic sampleWave(output logic [7:0] wave);
    wave = 8'd0;
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      wave[i] = obsClk;
    end
  endtask

  task automatic waitRise(input int limit, output int found);
    logic prev;
    found = 0;
    prev  = obsClk;
    for (int i = 0; i < limit && found == 0; i++) begin
      stepCycle();
      if (!prev && obsClk) found = 1;
      prev = obsClk;
    end
  endtask

  task automatic measureHigh(output int len, output int ackIdx, output int ackCnt);
    len    = 0;
    ackIdx = -1;
    ackCnt = 0;
    while (obsClk && len < 64) begin
      if (obsAck) begin
        if (ackIdx < 0) ackIdx = len;
        ackCnt++;
      end
      len++;
      stepCycle();
    end
  endtask

  task automatic measureLow(output int len);
    len = 0;
    while (!obsClk && len < 64) begin
      len++;
      stepCycle();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] wave;
    int found, len, ackIdx, ackCnt;

    useB        = 1'b0;
    resetbA     = 1'b0;
    resetbB     = 1'b0;
    ifA.req     = 1'b0;
    ifA.div_sel = 2'd0;
    ifB.req     = 1'b0;
    ifB.div_sel = 2'd0;

    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("rst_clk",   int'(obsClk),  1);
    checkOutput("rst_ack",   int'(obsAck),  0);
    checkOutput("rst_busy",  int'(obsBusy), 0);
    checkOutput("rst_sel",   int'(obsSel),  1);
    checkOutput("rst_selB",  int'(ifB.cur_sel), 1);

    @(negedge clk_in);
    resetbA = 1'b1;
    resetbB = 1'b1;
    sampleWave(wave);
    checkOutput("rel_wave", int'(wave), 8'b1001_1001);
    checkOutput("rel_busy", int'(obsBusy), 0);
    checkOutput("rel_sel",  int'(obsSel),  1);

    // div4 -> div16 with a 2-cycle hold
    applyStimulus(1'b1, 2'd3);
    stepCycle();
    checkOutput("t1_busy", int'(obsBusy), 1);
    checkOutput("t1_oldsel", int'(obsSel), 1);
    waitRise(20, found);
    checkOutput("t1_rise", found, 1);
    checkOutput("t1_sel", int'(obsSel), 3);
    checkOutput("t1_ack_at_switch", int'(obsAck), 0);
    measureHigh(len, ackIdx, ackCnt);
    checkOutput("t1_high", len, 10);
    checkOutput("t1_ackidx", ackIdx, 2);
    measureLow(len);
    checkOutput("t1_low", len, 8);
    measureHigh(len, ackIdx, ackCnt);
    checkOutput("t1_high2", len, 8);
    checkOutput("t1_held_busy", int'(obsBusy), 1);
    checkOutput("t1_held_ack", int'(obsAck), 1);
    checkOutput("t1_held_sel", int'(obsSel), 3);
    applyStimulus(1'b0, 2'd3);
    stepCycle();
    checkOutput("t1_ackfall", int'(obsAck), 0);
    checkOutput("t1_idle", int'(obsBusy), 0);

    // div16 -> div8
    applyStimulus(1'b1, 2'd2);
    stepCycle();
    waitRise(40, found);
    checkOutput("t2_rise", found, 1);
    checkOutput("t2_sel", int'(obsSel), 2);
    measureHigh(len, ackIdx, ackCnt);
    checkOutput("t2_high", len, 6);
    checkOutput("t2_ackidx", ackIdx, 2);
    applyStimulus(1'b0, 2'd2);
    stepCycle();
    checkOutput("t2_ackfall", int'(obsAck), 0);

    // same-ratio request: immediate ack, waveform untouched
    waitRise(20, found);
    checkOutput("t3_rise", found, 1);
    applyStimulus(1'b1, 2'd2);
    stepCycle();
    checkOutput("t3_ack", int'(obsAck), 1);
    checkOutput("t3_busy", int'(obsBusy), 1);
    checkOutput("t3_sel", int'(obsSel), 2);
    applyStimulus(1'b0, 2'd2);
    stepCycle();
    checkOutput("t3_ackfall", int'(obsAck), 0);
    checkOutput("t3_idle", int'(obsBusy), 0);
    measureHigh(len, ackIdx, ackCnt);
    checkOutput("t3_high_rest", len, 2);
    measureLow(len);
    checkOutput("t3_low", len, 4);
    measureHigh(len, ackIdx, ackCnt);
    checkOutput("t3_high", len, 4);

    // one-cycle req pulse, div_sel disturbed during SYNC
    applyStimulus(1'b1, 2'd0);
    stepCycle();
    checkOutput("t4_busy", int'(obsBusy), 1);
    applyStimulus(1'b0, 2'd3);
    waitRise(20, found);
    checkOutput("t4_rise", found, 1);
    checkOutput("t4_sel", int'(obsSel), 0);
    measureHigh(len, ackIdx, ackCnt);
    checkOutput("t4_high", len, 3);
    checkOutput("t4_ackidx", ackIdx, 2);
    checkOutput("t4_ackcnt", ackCnt, 1);
    checkOutput("t4_ack_after", int'(obsAck), 0);
    checkOutput("t4_idle", int'(obsBusy), 0);
    checkOutput("t4_sel_after", int'(obsSel), 0);

    // reset while holding after a switch
    applyStimulus(1'b1, 2'd2);
    stepCycle();
    waitRise(10, found);
    checkOutput("t5_rise", found, 1);
    checkOutput("t5_hold_busy", int'(obsBusy), 1);
    checkOutput("t5_hold_sel", int'(obsSel), 2);
    resetbA = 1'b0;
    #1;
    checkOutput("t5_rst_clk", int'(obsClk), 1);
    checkOutput("t5_rst_ack", int'(obsAck), 0);
    checkOutput("t5_rst_busy", int'(obsBusy), 0);
    checkOutput("t5_rst_sel", int'(obsSel), 1);
    applyStimulus(1'b0, 2'd0);
    repeat (2) @(negedge clk_in);
    resetbA = 1'b1;
    sampleWave(wave);
    checkOutput("t5_wave", int'(wave), 8'b1001_1001);
    applyStimulus(1'b1, 2'd0);
    stepCycle();
    waitRise(10, found);
    checkOutput("t5_rise2", found, 1);
    checkOutput("t5_sel2", int'(obsSel), 0);
    measureHigh(len, ackIdx, ackCnt);
    checkOutput("t5_high", len, 3);
    checkOutput("t5_ackidx", ackIdx, 2);
    applyStimulus(1'b0, 2'd0);
    stepCycle();
    checkOutput("t5_ackfall", int'(obsAck), 0);
    checkOutput("t5_idle", int'(obsBusy), 0);

    // no-hold instance: div4 -> div16, then div16 -> div2
    useB = 1'b1;
    applyStimulus(1'b1, 2'd3);
    stepCycle();
    checkOutput("b1_busy", int'(obsBusy), 1);
    waitRise(10, found);
    checkOutput("b1_rise", found, 1);
    checkOutput("b1_sel", int'(obsSel), 3);
    checkOutput("b1_ack_at_switch", int'(obsAck), 1);
    measureHigh(len, ackIdx, ackCnt);
    checkOutput("b1_high", len, 8);
    applyStimulus(1'b0, 2'd3);
    stepCycle();
    checkOutput("b1_ackfall", int'(obsAck), 0);

    applyStimulus(1'b1, 2'd0);
    stepCycle();
    checkOutput("b2_busy", int'(obsBusy), 1);
    waitRise(40, found);
    checkOutput("b2_rise", found, 1);
    checkOutput("b2_sel", int'(obsSel), 0);
    checkOutput("b2_ack_at_switch", int'(obsAck), 1);
    measureHigh(len, ackIdx, ackCnt);
    checkOutput("b2_high", len, 1);
    checkOutput("b2_ackidx", ackIdx, 0);
    measureLow(len);
    checkOutput("b2_low", len, 1);
    measureHigh(len, ackIdx, ackCnt);
    checkOutput("b2_high2", len, 1);
    applyStimulus(1'b0, 2'd0);
    stepCycle();
    checkOutput("b2_ackfall", int'(obsAck), 0);
    checkOutput("b2_idle", int'(obsBusy), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
